// File: rtl/lc3b_types.sv
// Shared LC-3b types plus the instruction-cache geometry
// and FSM state encoding.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_data;

   localparam int ICACHE_SETS        = 8;
   localparam int ICACHE_OFFSET_BITS = 4;
   localparam int ICACHE_INDEX_BITS  = $clog2(ICACHE_SETS);
   localparam int ICACHE_TAG_BITS    =
      16 - ICACHE_OFFSET_BITS - ICACHE_INDEX_BITS;

   typedef logic [ICACHE_TAG_BITS-1:0]    lc3b_icache_tag;
   typedef logic [ICACHE_INDEX_BITS-1:0]  lc3b_icache_index;
   typedef logic [ICACHE_OFFSET_BITS-1:0] lc3b_icache_offset;

   typedef enum logic {
      LOOKUP,
      REFILL
   } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped icache:
// async read port, sync write port, valid bits cleared on rst.
module icache_array
   import lc3b_types::*;
#(
   parameter int NUM_SETS = ICACHE_SETS,
   parameter int TAG_W    = ICACHE_TAG_BITS,
   parameter int IDX      = $clog2(NUM_SETS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX-1:0]   rd_index,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output lc3b_data         rd_data,
   input  logic             wr_en,
   input  logic [IDX-1:0]   wr_index,
   input  logic [TAG_W-1:0] wr_tag,
   input  lc3b_data         wr_data
);

   logic [NUM_SETS-1:0] valid_q;
   logic [TAG_W-1:0]    tag_q  [NUM_SETS];
   lc3b_data            data_q [NUM_SETS];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   // Tag and data are qualified by valid, so they need no reset.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         tag_q[wr_index]  <= wr_tag;
         data_q[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits,
// misses stall fetch while a line is refilled over stb/cyc/ack.
module icache_direct
   import lc3b_types::*;
#(
   parameter int NUM_SETS    = ICACHE_SETS,
   parameter int OFFSET_BITS = ICACHE_OFFSET_BITS
) (
   input  logic     clk,
   input  logic     rst,
   input  lc3b_word imem_address,
   input  logic     imem_action_stb,
   input  logic     imem_action_cyc,
   output lc3b_data imem_rdata,
   output logic     imem_resp,
   output lc3b_word pmem_address,
   output logic     pmem_stb,
   output logic     pmem_cyc,
   input  lc3b_data pmem_rdata,
   input  logic     pmem_ack
);

   localparam int IDX   = $clog2(NUM_SETS);
   localparam int TAG_W = 16 - OFFSET_BITS - IDX;
   localparam lc3b_word LINE_MASK =
      16'hFFFF << OFFSET_BITS;

   icache_state_t    state_q;
   lc3b_word         miss_addr;
   logic             stb_q;
   logic             request;
   logic             hit;
   logic             fill;
   logic [IDX-1:0]   index;
   logic [TAG_W-1:0] tag;
   logic             set_valid;
   logic [TAG_W-1:0] set_tag;

   assign index   = imem_address[OFFSET_BITS+IDX-1:OFFSET_BITS];
   assign tag     = imem_address[15:OFFSET_BITS+IDX];
   assign request = imem_action_stb & imem_action_cyc;
   assign hit     = request & set_valid & (set_tag == tag);
   assign fill    = (state_q == REFILL) & pmem_ack & ~rst;

   icache_array #(
      .NUM_SETS (NUM_SETS),
      .TAG_W    (TAG_W)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .rd_index (index),
      .rd_valid (set_valid),
      .rd_tag   (set_tag),
      .rd_data  (imem_rdata),
      .wr_en    (fill),
      .wr_index (miss_addr[OFFSET_BITS+IDX-1:OFFSET_BITS]),
      .wr_tag   (miss_addr[15:OFFSET_BITS+IDX]),
      .wr_data  (pmem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= LOOKUP;
         miss_addr <= '0;
         stb_q     <= 1'b0;
      end else begin
         unique case (state_q)
            LOOKUP: begin
               if (request && !hit) begin
                  miss_addr <= imem_address & LINE_MASK;
                  stb_q     <= 1'b1;
                  state_q   <= REFILL;
               end
            end
            REFILL: begin
               if (pmem_ack) begin
                  stb_q   <= 1'b0;
                  state_q <= LOOKUP;
               end
            end
         endcase
      end
   end

   // Gate with rst so a reset cycle never reports a hit or a bus request.
   assign imem_resp    = hit & (state_q == LOOKUP) & ~rst;
   assign pmem_stb     = stb_q & ~rst;
   assign pmem_cyc     = stb_q & ~rst;
   assign pmem_address = miss_addr;

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios
// plus a randomized run against a line-level cache model.
module tb_icache_direct;
   import lc3b_types::*;

   logic     clk = 1'b0;
   logic     rst;
   lc3b_word imem_address;
   logic     imem_action_stb;
   logic     imem_action_cyc;
   lc3b_data imem_rdata;
   logic     imem_resp;
   lc3b_word pmem_address;
   logic     pmem_stb;
   logic     pmem_cyc;
   lc3b_data pmem_rdata;
   logic     pmem_ack;

   int vectors = 0;
   int miscompares = 0;

   bit       m_valid [8];
   int       m_tag   [8];
   lc3b_data m_data  [8];

   icache_direct dut (
      .clk             (clk),
      .rst             (rst),
      .imem_address    (imem_address),
      .imem_action_stb (imem_action_stb),
      .imem_action_cyc (imem_action_cyc),
      .imem_rdata      (imem_rdata),
      .imem_resp       (imem_resp),
      .pmem_address    (pmem_address),
      .pmem_stb        (pmem_stb),
      .pmem_cyc        (pmem_cyc),
      .pmem_rdata      (pmem_rdata),
      .pmem_ack        (pmem_ack)
   );

   always #5 clk = ~clk;

   function automatic lc3b_data rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Inputs change 1 time unit after the rising edge; checks sit mid-cycle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic probe();
      #3;
   endtask

   task automatic req(input lc3b_word a, input logic on);
      imem_address    = a;
      imem_action_stb = on;
      imem_action_cyc = on;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pmem_ack = 1'b0;
      pmem_rdata = '0;
      req(16'h0000, 1'b0);
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      probe();
      vectors++;
      if ({imem_resp, pmem_stb, pmem_cyc} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_ctl resp/stb/cyc=%b want 000",
                  {imem_resp, pmem_stb, pmem_cyc});
      end
      vectors++;
      if (pmem_address !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_addr got %h want 0000", pmem_address);
      end
      step();
   endtask

   lc3b_data line_a;

   task automatic test_cold_miss();
      line_a = rand_line();
      req(16'h0010, 1'b1);
      probe();
      vectors++;
      if (imem_resp !== 1'b0 || pmem_stb !== 1'b0) begin
         miscompares++;
         $display("FAIL cold_c0 resp=%b stb=%b want 0 0",
                  imem_resp, pmem_stb);
      end
      for (int c = 1; c <= 4; c++) begin
         step();
         if (c == 4) begin
            pmem_ack = 1'b1;
            pmem_rdata = line_a;
         end
         probe();
         vectors++;
         if (pmem_stb !== 1'b1 || pmem_cyc !== 1'b1 ||
             pmem_address !== 16'h0010 || imem_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL cold_c%0d stb=%b cyc=%b addr=%h resp=%b want 1 1 0010 0",
                     c, pmem_stb, pmem_cyc, pmem_address, imem_resp);
         end
      end
      step();
      pmem_ack = 1'b0;
      probe();
      vectors++;
      if (imem_resp !== 1'b1 || imem_rdata !== line_a) begin
         miscompares++;
         $display("FAIL cold_c5 resp=%b data=%h want 1 %h",
                  imem_resp, imem_rdata, line_a);
      end
      step();
   endtask

   task automatic test_hit();
      req(16'h001E, 1'b1);
      probe();
      vectors++;
      if (imem_resp !== 1'b1 || imem_rdata !== line_a ||
          pmem_stb !== 1'b0) begin
         miscompares++;
         $display("FAIL hit resp=%b stb=%b data=%h want 1 0 %h",
                  imem_resp, pmem_stb, imem_rdata, line_a);
      end
      step();
   endtask

   // One full miss/refill on address a, ack after 'delay' refill cycles.
   task automatic test_miss_fill(input string nm, input lc3b_word a,
                                 input int delay, input lc3b_data d);
      req(a, 1'b1);
      probe();
      vectors++;
      if (imem_resp !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_miss resp=%b want 0", nm, imem_resp);
      end
      for (int c = 0; c <= delay; c++) begin
         step();
         if (c == delay) begin
            pmem_ack = 1'b1;
            pmem_rdata = d;
         end
         probe();
         vectors++;
         if (pmem_stb !== 1'b1 || pmem_address !== (a & 16'hFFF0)) begin
            miscompares++;
            $display("FAIL %s_bus stb=%b addr=%h want 1 %h",
                     nm, pmem_stb, pmem_address, a & 16'hFFF0);
         end
      end
      step();
      pmem_ack = 1'b0;
      probe();
      vectors++;
      if (imem_resp !== 1'b1 || imem_rdata !== d) begin
         miscompares++;
         $display("FAIL %s_fill resp=%b data=%h want 1 %h",
                  nm, imem_resp, imem_rdata, d);
      end
      step();
   endtask

   task automatic test_conflict();
      test_miss_fill("conf_new", 16'h0090, 1, rand_line());
      test_miss_fill("conf_old", 16'h0010, 2, line_a);
   endtask

   task automatic test_redirect();
      lc3b_data l1;
      l1 = rand_line();
      req(16'h0100, 1'b1);
      step();
      req(16'h0200, 1'b1);
      probe();
      vectors++;
      if (pmem_stb !== 1'b1 || pmem_address !== 16'h0100) begin
         miscompares++;
         $display("FAIL redir_hold stb=%b addr=%h want 1 0100",
                  pmem_stb, pmem_address);
      end
      step();
      pmem_ack = 1'b1;
      pmem_rdata = l1;
      probe();
      vectors++;
      if (imem_resp !== 1'b0 || pmem_address !== 16'h0100) begin
         miscompares++;
         $display("FAIL redir_ack resp=%b addr=%h want 0 0100",
                  imem_resp, pmem_address);
      end
      step();
      pmem_ack = 1'b0;
      req(16'h0104, 1'b1);
      probe();
      vectors++;
      if (imem_resp !== 1'b1 || imem_rdata !== l1) begin
         miscompares++;
         $display("FAIL redir_inst resp=%b data=%h want 1 %h",
                  imem_resp, imem_rdata, l1);
      end
      step();
      test_miss_fill("redir_new", 16'h0200, 0, rand_line());
   endtask

   task automatic test_reset_mid();
      req(16'h0300, 1'b1);
      step();
      probe();
      vectors++;
      if (pmem_stb !== 1'b1) begin
         miscompares++;
         $display("FAIL rmid_pre stb=%b want 1", pmem_stb);
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      req(16'h0300, 1'b0);
      probe();
      vectors++;
      if (pmem_stb !== 1'b0 || pmem_cyc !== 1'b0) begin
         miscompares++;
         $display("FAIL rmid_abort stb=%b cyc=%b want 0 0",
                  pmem_stb, pmem_cyc);
      end
      step();
      pmem_ack = 1'b1;
      pmem_rdata = rand_line();
      step();
      pmem_ack = 1'b0;
      test_miss_fill("rmid_again", 16'h0300, 1, line_a);
   endtask

   task automatic test_idle();
      for (int i = 0; i < 10; i++) begin
         req(16'($urandom_range(0, 16'hFFFF)), 1'b0);
         imem_action_cyc = i[0];
         probe();
         vectors++;
         if (imem_resp !== 1'b0 || pmem_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_%0d resp=%b stb=%b want 0 0",
                     i, imem_resp, pmem_stb);
         end
         step();
      end
      req(16'h030C, 1'b1);
      probe();
      vectors++;
      if (imem_resp !== 1'b1 || imem_rdata !== line_a) begin
         miscompares++;
         $display("FAIL idle_keep resp=%b data=%h want 1 %h",
                  imem_resp, imem_rdata, line_a);
      end
      step();
   endtask

   task automatic test_random();
      test_reset();
      for (int n = 0; n < 60; n++) begin
         lc3b_word a;
         int idx, tg, dly;
         bit on, mhit;
         lc3b_data d;
         a   = 16'($urandom_range(0, 16'h03FF));
         idx = (int'(a) / 16) % 8;
         tg  = int'(a) / 128;
         on  = ($urandom_range(0, 4) != 0);
         mhit = on && m_valid[idx] && (m_tag[idx] == tg);
         req(a, on);
         if (!on) imem_action_cyc = $urandom_range(0, 1) != 0;
         probe();
         vectors++;
         if (imem_resp !== mhit) begin
            miscompares++;
            $display("FAIL rnd_resp n=%0d a=%h got %b want %b",
                     n, a, imem_resp, mhit);
         end
         if (mhit) begin
            vectors++;
            if (imem_rdata !== m_data[idx]) begin
               miscompares++;
               $display("FAIL rnd_data n=%0d a=%h got %h want %h",
                        n, a, imem_rdata, m_data[idx]);
            end
         end
         step();
         if (on && !mhit) begin
            dly = $urandom_range(0, 3);
            d = rand_line();
            for (int c = 0; c <= dly; c++) begin
               req(16'($urandom_range(0, 16'hFFFF)),
                   $urandom_range(0, 1) != 0);
               if (c == dly) begin
                  pmem_ack = 1'b1;
                  pmem_rdata = d;
               end
               probe();
               vectors++;
               if (pmem_stb !== 1'b1 || imem_resp !== 1'b0 ||
                   pmem_address !== (a & 16'hFFF0)) begin
                  miscompares++;
                  $display("FAIL rnd_bus n=%0d stb=%b resp=%b addr=%h want 1 0 %h",
                           n, pmem_stb, imem_resp, pmem_address,
                           a & 16'hFFF0);
               end
               step();
            end
            pmem_ack = 1'b0;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_data[idx]  = d;
         end else if ($urandom_range(0, 3) == 0) begin
            req(a, 1'b0);
            pmem_ack = 1'b1;
            pmem_rdata = rand_line();
            step();
            pmem_ack = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hit();
      test_conflict();
      test_redirect();
      test_reset_mid();
      test_idle();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
